kbd_scan_ctrl: RTL
==================

KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 The block SHALL have parameter FILT_LEN, default 4, meaning consecutive equal synchronized samples required to accept a new k_clk level.
REQ-002 The block SHALL have parameter TIMEOUT, default 50000, meaning clk cycles allowed between k_clk falling edges inside a frame.
REQ-003 The block SHALL have parameter DEPTH, default 8 (power of two), meaning scan-code FIFO entries.
REQ-004 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-006 The block SHALL have port k_clk, input, 1, meaning the raw PS/2 clock, asynchronous to clk.
REQ-007 The block SHALL have port k_data, input, 1, meaning the raw PS/2 data, asynchronous to clk.
REQ-008 The block SHALL have port rd, input, 1, meaning a pop request for the FIFO head.
REQ-009 The block SHALL have port clr, input, 1, meaning clear the sticky err and overflow flags.
REQ-010 The block SHALL have port data, output, 8, meaning the FIFO head scan code, or 8'h00 when the FIFO is empty.
REQ-011 The block SHALL have port valid, output, 1, meaning the FIFO is not empty.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1, meaning FIFO occupancy.
REQ-013 The block SHALL have port interrupt, output, 1, meaning a one-cycle pulse per accepted scan code.
REQ-014 The block SHALL have port err, output, 1, meaning a sticky frame error (start, parity, stop or timeout).
REQ-015 The block SHALL have port overflow, output, 1, meaning a sticky flag set when a good frame is dropped because the FIFO is full.

Function
REQ-016 k_clk and k_data SHALL each pass through a 2-flop synchronizer; the filtered k_clk level SHALL change only after FILT_LEN identical synchronized samples.
REQ-017 A falling edge SHALL be a filtered k_clk transition 1->0, flagged for exactly one clk cycle; k_data SHALL be sampled from its synchronized value in that cycle.
REQ-018 The FSM SHALL have states IDLE, DATA, PARITY and STOP, with bit counter 0..7.
REQ-019 In IDLE, a falling edge with k_data=0 SHALL enter DATA with the counter cleared; a falling edge with k_data=1 SHALL set err and stay in IDLE.
REQ-020 In DATA, each falling edge SHALL shift k_data in LSB-first; after the 8th bit the FSM SHALL go to PARITY.
REQ-021 In PARITY, the edge SHALL record the parity bit; the check is odd parity over 8 data bits plus the parity bit; the FSM SHALL go to STOP.
REQ-022 In STOP, the edge SHALL always return the FSM to IDLE; the frame is good only if parity is odd and stop=1, otherwise err SHALL set and the byte SHALL be discarded.
REQ-023 Timeout: in any non-IDLE state, TIMEOUT clk cycles without a falling edge SHALL force IDLE, set err and discard the partial byte.
REQ-024 A good frame SHALL push the byte in the clk cycle after the stop edge; valid, count and interrupt SHALL update on that same following edge (1-cycle latency).
REQ-025 interrupt SHALL be high for exactly one cycle per pushed byte and SHALL NOT pulse for dropped or erroneous frames.
REQ-026 Push when full with no pop SHALL drop the byte, set overflow and leave the FIFO unchanged.
REQ-027 Push and rd in the same cycle SHALL both take effect, including when full (no overflow) and when empty (the byte stays in; the pop is ignored).
REQ-028 rd when empty SHALL be ignored; count SHALL never underflow or exceed DEPTH.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 A clr coinciding with a new error or overflow event SHALL leave the flag set (set wins).

Reset
REQ-031 With rst=1 at a clk edge: FSM=IDLE, counter=0, filters and synchronizers=1 (idle bus), FIFO empty, data=8'h00, valid=0, count=0, interrupt=0, err=0, overflow=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no push; the next frame after release SHALL be received normally.

Verification
REQ-033 A frame with start 0, data 0x1C LSB-first, parity 0 and stop 1 SHALL produce interrupt one cycle after the stop edge, followed by valid=1, data=8'h1C, count=1.
REQ-034 The same frame with parity 1 SHALL produce err=1, valid=0 and no interrupt; a subsequent clr=1 SHALL give err=0.
REQ-035 With DEPTH=8, nine good frames and no rd SHALL give count=8 and overflow=1; popping all eight SHALL return the codes in order.
REQ-036 Stopping k_clk after 4 data bits SHALL give err=1 and FSM IDLE after TIMEOUT cycles; a following good frame 0x5A SHALL be received intact.
REQ-037 A 1-cycle low glitch on k_clk with FILT_LEN=4 SHALL cause no state change; rd coinciding with a push on a full FIFO SHALL keep count=8 and overflow=0.

Source files
------------

// File: rtl/kbd_scan_ctrl.sv
// PS/2 keyboard receiver: synchronizes and filters k_clk/k_data, decodes
// 11-bit frames, and queues good scan codes in a small FIFO with sticky error flags.
module kbd_scan_ctrl #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TIMEOUT  = 50000,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       k_clk,
    input  logic                       k_data,
    input  logic                       rd,
    input  logic                       clr,
    output logic [7:0]                 data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       interrupt,
    output logic                       err,
    output logic                       overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic          kc_s1_q, kc_s2_q, kd_s1_q, kd_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    push_byte_q, push_byte_d;
    logic          frame_err;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          irq_q, irq_d, err_q, err_d, ovf_q, ovf_d;
    logic          full, empty, do_pop, do_push, ovf_evt;

    // The filtered level flips only after FILT_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (kc_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = kc_s2_q;
            else                             fcnt_d = fcnt_q + FW'(1);
        end
        fall_d = filt_q & ~filt_d;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = '0;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        frame_err   = 1'b0;
        case (state_q)
            ST_IDLE: if (fall_q) begin
                if (!kd_s2_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end else begin
                    frame_err = 1'b1;
                end
            end
            ST_DATA: if (fall_q) begin
                shift_d = {kd_s2_q, shift_q[7:1]};
                if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
            ST_PARITY: if (fall_q) begin
                par_d   = kd_s2_q;
                state_d = ST_STOP;
            end
            ST_STOP: if (fall_q) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                if ((^{shift_q, par_q}) && kd_s2_q) begin
                    push_d      = 1'b1;
                    push_byte_d = shift_q;
                end else begin
                    frame_err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && !fall_q) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                frame_err = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // Simultaneous push and pop on a full FIFO writes into the slot being vacated.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = rd && !empty;
        do_push  = push_q && (!full || do_pop);
        ovf_evt  = push_q && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        irq_d = do_push;
        err_d = (err_q & ~clr) | frame_err;
        ovf_d = (ovf_q & ~clr) | ovf_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kc_s1_q     <= 1'b1;
            kc_s2_q     <= 1'b1;
            kd_s1_q     <= 1'b1;
            kd_s2_q     <= 1'b1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            fall_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            kc_s1_q     <= k_clk;
            kc_s2_q     <= kc_s1_q;
            kd_s1_q     <= k_data;
            kd_s2_q     <= kd_s1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_byte_q;
    end

    assign data      = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign valid     = !empty;
    assign count     = count_q;
    assign interrupt = irq_q;
    assign err       = err_q;
    assign overflow  = ovf_q;
endmodule
